tach_capture: RTL and testbench
===============================

TACH_CAPTURE -- requirements
Module: tach_capture

Interface
REQ-001 Parameter FILT_LEN, default 4: consecutive equal samples required before a filtered input changes (range 1..15).
REQ-002 Parameter TIMEOUT, default 25000000: clocks without an I_spd1 rising edge before the block declares a stall (1 s at 25 MHz).
REQ-003 I_clk  input  1  system clock, 25 MHz.
REQ-004 I_reset_n  input  1  asynchronous reset, active low.
REQ-005 I_en  input  1  capture enable, active high, level.
REQ-006 I_spd1  input  1  tachometer channel 1, asynchronous to I_clk.
REQ-007 I_spd2  input  1  tachometer channel 2, asynchronous to I_clk.
REQ-008 I_clr  input  1  synchronous clear of the pulse counter, level, active high.
REQ-009 O_period  output  32  clocks between the last two filtered spd1 rising edges.
REQ-010 O_phase  output  32  clocks from the spd1 rising edge to the first following spd2 rising edge.
REQ-011 O_dir  output  1  0 = spd1 leads spd2; 1 = spd2 leads spd1.
REQ-012 O_pulse_cnt  output  32  signed-agnostic up/down pulse count.
REQ-013 O_valid  output  1  one-cycle strobe when O_period is updated.
REQ-014 O_stopped  output  1  high while no spd1 edge has occurred within TIMEOUT.

Function
REQ-015 Each input SHALL pass through a 2-FF synchroniser and then a filter; the filtered value changes only after FILT_LEN consecutive identical synchronised samples; input-to-filtered latency is 2+FILT_LEN clocks.
REQ-016 Rising/falling edge strobes SHALL be derived from the filtered signals, one clock each.
REQ-017 FSM states: IDLE, ARM, MEAS; I_en low forces IDLE from any state on the next clock.
REQ-018 IDLE: period counter 0, O_period=0, O_phase=0, O_stopped=0; I_en high -> ARM.
REQ-019 ARM: on spd1 rise clear the period counter, sample filtered spd2 into O_dir (spd2 low -> 0, high -> 1), -> MEAS; no O_valid.
REQ-020 MEAS: the period counter increments every clock, saturating at 32'hFFFFFFFF.
REQ-021 MEAS, spd1 rise: O_period <= counter+1, O_valid high the next clock, O_dir resampled as in REQ-019, counter restarts at 0, phase capture re-armed.
REQ-022 MEAS, first spd2 rise after a spd1 rise: O_phase <= counter+1; subsequent spd2 rises in the same period are ignored.
REQ-023 spd1 and spd2 rising in the same clock: O_phase <= 0, O_dir unchanged.
REQ-024 Counter reaching TIMEOUT in ARM or MEAS: O_stopped <= 1, O_period <= 0, -> ARM; O_stopped clears on the next spd1 rise.
REQ-025 Each filtered spd1 falling edge in MEAS SHALL increment O_pulse_cnt when O_dir=0 and decrement it when O_dir=1, wrapping modulo 2^32.
REQ-026 I_clr high: O_pulse_cnt <= 0; clear wins over a simultaneous count edge.
REQ-027 O_pulse_cnt SHALL hold its value while I_en is low.

Reset
REQ-028 While I_reset_n is low: FSM=IDLE, all filter and synchroniser flops 0, all outputs 0.
REQ-029 Reset asserted mid-measurement SHALL take effect immediately, and no O_valid SHALL be issued for the interrupted period.

Structure
REQ-030 Shared package tach_pkg SHALL hold the FSM state encoding and the FILT_LEN/TIMEOUT default constants.
REQ-031 One sub-module, tach_filter (synchroniser + glitch filter + edge strobes), SHALL be instantiated once per channel.
REQ-032 All flops SHALL be on I_clk with asynchronous I_reset_n; there SHALL be no other clocks or generated clocks.

Verification
REQ-033 spd1 period 1000 clks, 50 % duty, spd2 lagging 250 clks -> after the second spd1 rise: O_period=1000, O_phase=250, O_dir=0, O_valid single pulse; O_pulse_cnt +1 per period.
REQ-034 Same stimulus with spd2 leading by 250 clks, O_pulse_cnt starting at 0 -> O_dir=1, O_phase=750, O_pulse_cnt=32'hFFFFFFFF after the first falling edge.
REQ-035 FILT_LEN=4, 2-clock high glitch on I_spd1 -> no edge, no O_valid, O_pulse_cnt unchanged; 5-clock pulse -> one rising and one falling edge.
REQ-036 TIMEOUT=5000, spd1 stopped -> O_stopped=1 and O_period=0 exactly 5000 clks after the last rise; on restart the first O_valid follows the second rise.
REQ-037 I_clr asserted in the same clock as a counting spd1 fall -> O_pulse_cnt=0; I_reset_n pulsed low mid-period -> all outputs 0, FSM=IDLE, no O_valid.

Source files
------------

// File: rtl/tach_pkg.sv
// tach_pkg: FSM state encoding and default parameters shared by the tachometer capture block.
package tach_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam int FILT_LEN_DEF = 4;
  localparam int TIMEOUT_DEF  = 25000000;
endpackage

// File: rtl/tach_filter.sv
// tach_filter: two-flop synchroniser, run-length glitch filter and one-clock edge strobes for one channel.
module tach_filter
  import tach_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic [3:0] run;
  logic       level_d;
  // run counts consecutive synchronised samples that disagree with the filtered level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      run     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], din};
      level_d <= level;
      if (sync[1] == level) run <= '0;
      else if (run == 4'(FILT_LEN - 1)) begin
        run   <= '0;
        level <= sync[1];
      end else run <= run + 4'd1;
    end
  end
  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
endmodule

// File: rtl/tach_capture.sv
// tach_capture: measures tachometer period, spd1->spd2 phase and direction, and keeps an up/down pulse count.
module tach_capture
  import tach_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_en,
  input  logic        I_spd1,
  input  logic        I_spd2,
  input  logic        I_clr,
  output logic [31:0] O_period,
  output logic [31:0] O_phase,
  output logic        O_dir,
  output logic [31:0] O_pulse_cnt,
  output logic        O_valid,
  output logic        O_stopped
);
  logic [1:0]  state;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic        armed;
  logic        tmo;
  logic        s1_lvl, s1_rise, s1_fall;
  logic        s2_lvl, s2_rise, unused_s2_fall;
  tach_filter #(.FILT_LEN(FILT_LEN)) u_spd1 (
    .clk(I_clk), .rst_n(I_reset_n), .din(I_spd1), .level(s1_lvl), .rise(s1_rise), .fall(s1_fall)
  );
  tach_filter #(.FILT_LEN(FILT_LEN)) u_spd2 (
    .clk(I_clk), .rst_n(I_reset_n), .din(I_spd2), .level(s2_lvl), .rise(s2_rise), .fall(unused_s2_fall)
  );
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
  assign tmo     = cnt == 32'(TIMEOUT - 1);
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      O_period    <= '0;
      O_phase     <= '0;
      O_dir       <= 1'b0;
      O_pulse_cnt <= '0;
      O_valid     <= 1'b0;
      O_stopped   <= 1'b0;
    end else begin
      O_valid <= 1'b0;
      if (I_clr) O_pulse_cnt <= '0;
      else if (I_en && state == ST_MEAS && s1_fall)
        O_pulse_cnt <= O_dir ? O_pulse_cnt - 32'd1 : O_pulse_cnt + 32'd1;
      if (!I_en) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        armed     <= 1'b0;
        O_period  <= '0;
        O_phase   <= '0;
        O_stopped <= 1'b0;
      end else if (state == ST_IDLE) state <= ST_ARM;
      else begin
        cnt <= cnt_inc;
        if (s1_rise) begin
          cnt       <= '0;
          armed     <= ~s2_rise;
          O_stopped <= 1'b0;
          state     <= ST_MEAS;
          // coincident edges give zero phase and leave the direction as it was
          if (s2_rise) O_phase <= '0;
          else O_dir <= s2_lvl;
          if (state == ST_MEAS) begin
            O_period <= cnt_inc;
            O_valid  <= 1'b1;
          end
        end else if (tmo) begin
          cnt       <= '0;
          armed     <= 1'b0;
          O_stopped <= 1'b1;
          O_period  <= '0;
          state     <= ST_ARM;
        end else if (state == ST_MEAS && armed && s2_rise) begin
          O_phase <= cnt_inc;
          armed   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tach_capture.sv
// tb_tach_capture: vector table of tach waveforms with an O_valid scoreboard, plus glitch, timeout, clear and reset sequences.
module tb_tach_capture;
  import tach_pkg::*;
  localparam int TMO = 5000;
  logic        clk = 1'b0;
  logic        rst_n, en, spd1, spd2, clr;
  logic [31:0] period, phase, pulse_cnt;
  logic        dir, valid, stopped;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  typedef struct {
    logic [31:0] period;
    logic [31:0] phase;
    logic        dir;
  } exp_t;
  typedef struct {
    int          per;
    int          off;
    int          exp_phase;
    logic        exp_dir;
    logic [31:0] exp_pulse;
  } vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];
  tach_capture #(.FILT_LEN(4), .TIMEOUT(TMO)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .I_en(en), .I_spd1(spd1), .I_spd2(spd2), .I_clr(clr),
    .O_period(period), .O_phase(phase), .O_dir(dir), .O_pulse_cnt(pulse_cnt),
    .O_valid(valid), .O_stopped(stopped)
  );
  always #20 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic wave(input int per, input int off, input int i);
    int p;
    p = ((i - off) % per + per) % per;
    return p < per / 2;
  endfunction
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic gap(input logic s2);
    en = 1'b0; spd1 = 1'b0; spd2 = s2; clr = 1'b0;
    repeat (12) tick();
    en = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  task automatic pulse1(input int hi, input int lo);
    spd1 = 1'b1;
    repeat (hi) tick();
    spd1 = 1'b0;
    repeat (lo) tick();
  endtask
  task automatic run_entry(input vec_t v);
    gap(wave(v.per, v.off, 0));
    for (int k = 0; k < 3; k++) sb.push_back('{32'(v.per), 32'(v.exp_phase), v.exp_dir});
    for (int i = 0; i < 3 * v.per + 10; i++) begin
      spd1 = (i % v.per) < v.per / 2;
      spd2 = wave(v.per, v.off, i);
      tick();
    end
    repeat (10) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("pulse_cnt", pulse_cnt, v.exp_pulse);
  endtask
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got period %0d expected no strobe", period);
      end else begin
        e = sb.pop_front();
        chk("period", period, e.period);
        chk("phase", phase, e.phase);
        chk("dir", {31'd0, dir}, {31'd0, e.dir});
      end
    end
  end
  initial begin
    int r0, r1, r2, r3, r4, r5;
    tbl[0] = '{1000, 250, 250, 1'b0, 32'd3};
    tbl[1] = '{1000, 750, 750, 1'b1, 32'hFFFFFFFD};
    tbl[2] = '{400, 100, 100, 1'b0, 32'd3};
    tbl[3] = '{2000, 1500, 1500, 1'b1, 32'hFFFFFFFD};
    tbl[4] = '{64, 10, 10, 1'b0, 32'd3};
    tbl[5] = '{64, 40, 40, 1'b1, 32'hFFFFFFFD};
    rst_n = 1'b0; en = 1'b0; spd1 = 1'b0; spd2 = 1'b0; clr = 1'b0;
    repeat (3) tick();
    chk("rst_period", period, 32'd0);
    chk("rst_phase", phase, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_pulse", pulse_cnt, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_stopped", {31'd0, stopped}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    for (int t = 0; t < 6; t++) run_entry(tbl[t]);
    // spd2 leading: first counted fall wraps the counter below zero
    gap(wave(1000, 750, 0));
    for (int i = 0; i < 520; i++) begin
      spd1 = (i % 1000) < 500;
      spd2 = wave(1000, 750, i);
      tick();
    end
    chk("lead_first_fall", pulse_cnt, 32'hFFFFFFFF);
    chk("lead_dir", {31'd0, dir}, 32'd1);
    // glitch rejection then a 5-clock pulse that passes
    gap(1'b0);
    r0 = cyc;
    pulse1(20, 20);
    chk("glitch_pre", pulse_cnt, 32'd1);
    pulse1(2, 20);
    chk("glitch_hold", pulse_cnt, 32'd1);
    r1 = cyc;
    sb.push_back('{32'(r1 - r0), 32'd0, 1'b0});
    pulse1(5, 20);
    chk("pulse5_cnt", pulse_cnt, 32'd2);
    chk("pulse5_sb", 32'(sb.size()), 32'd0);
    // stall detection measured from the last rise
    while (cyc < r1 + TMO + 6) tick();
    @(negedge clk);
    chk("tmo_before", {31'd0, stopped}, 32'd0);
    tick();
    @(negedge clk);
    chk("tmo_stopped", {31'd0, stopped}, 32'd1);
    chk("tmo_period", period, 32'd0);
    r2 = cyc + 1;
    tick();
    pulse1(20, 20);
    chk("restart_clear", {31'd0, stopped}, 32'd0);
    r3 = cyc;
    sb.push_back('{32'(r3 - r2), 32'd0, 1'b0});
    pulse1(20, 20);
    chk("restart_sb", 32'(sb.size()), 32'd0);
    // clear coinciding with a counting fall
    r4 = cyc;
    sb.push_back('{32'(r4 - r3), 32'd0, 1'b0});
    spd1 = 1'b1;
    repeat (20) tick();
    chk("clr_pre", pulse_cnt, 32'd4);
    spd1 = 1'b0;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("clr_wins", pulse_cnt, 32'd0);
    // reset in the middle of a period
    r5 = cyc;
    sb.push_back('{32'(r5 - r4), 32'd0, 1'b0});
    pulse1(20, 200);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_period", period, 32'd0);
    chk("mid_rst_phase", phase, 32'd0);
    chk("mid_rst_dir", {31'd0, dir}, 32'd0);
    chk("mid_rst_pulse", pulse_cnt, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_stopped", {31'd0, stopped}, 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse1(20, 20);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);
    chk("post_rst_period", period, 32'd0);
    chk("post_rst_pulse", pulse_cnt, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
